// File: rtl/func_min_pkg.sv
// Shared types and widths for the minimised-function sweep controller.
package func_min_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

    localparam int N_IN  = 4;
    localparam int TT_W  = 16;
    localparam int ERR_W = 5;
endpackage

// File: rtl/func_min_vec_gen.sv
// Combinational sweep index -> function input vector; Gray order when FUNC_MIN_SWEEP_GRAY_EN is defined.
module func_min_vec_gen
    import func_min_pkg::*;
(
    input  logic [N_IN-1:0] idx_i,
    output logic [N_IN-1:0] vec_o
);

`ifdef FUNC_MIN_SWEEP_GRAY_EN
    // Only one function input toggles per step, limiting glitch-induced mis-samples.
    assign vec_o = idx_i ^ (idx_i >> 1);
`else
    assign vec_o = idx_i;
`endif

endmodule

// File: rtl/func_min_sweep_ctrl.sv
// Self-test sweep of a 4-input function block: 16 vectors x (SETTLE_CYCLES+1) cycles, done one cycle later;
// start ignored while busy, abort returns to IDLE. Vector order set by FUNC_MIN_SWEEP_GRAY_EN (binary if undefined).
module func_min_sweep_ctrl
    import func_min_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [TT_W-1:0]  expected,
    input  logic             z,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [TT_W-1:0]  tt,
    output logic [ERR_W-1:0] err_count,
    output logic [N_IN-1:0]  first_err_idx
);

    state_e           state_q, state_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TT_W-1:0]  exp_q, exp_d;
    logic [TT_W-1:0]  tt_q, tt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [N_IN-1:0]  first_q, first_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [N_IN-1:0]  vec_nxt;

    // Vector is generated from the next index and registered, so a..d are glitch-free.
    func_min_vec_gen u_vec_gen (
        .idx_i (idx_d),
        .vec_o (vec_nxt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;
        busy_d  = busy_q;

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        exp_d   = expected;
                        idx_d   = '0;
                        cnt_d   = '0;
                        tt_d    = '0;
                        err_d   = '0;
                        first_d = '0;
                        pass_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    // vec_q still holds vec(idx_q) here; results are indexed by vector value.
                    tt_d[vec_q] = z;
                    if (z != exp_q[vec_q]) begin
                        err_d = err_q + 1'b1;
                        if (err_q == '0) first_d = vec_q;
                    end
                    if (idx_q == '1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SETTLE;
                    end
                end
                DONE: begin
                    pass_d  = (err_q == '0);
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        vec_d = (state_d == SETTLE || state_d == SAMPLE) ? vec_nxt : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            vec_q   <= vec_d;
        end
    end

    assign {a, b, c, d}  = vec_q;
    assign busy          = busy_q;
    assign done          = (state_q == DONE);
    assign pass          = pass_q;
    assign tt            = tt_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_func_min_sweep_ctrl.sv
// Scoreboarded bench for func_min_sweep_ctrl against a truth-table model of the function block.
module tb_func_min_sweep_ctrl;

    localparam int S = 2;
    localparam int SWEEP = 16 * (S + 1);

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  err;
        logic [3:0]  first;
        logic        pass;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] expected = '0;
    logic [15:0] ftab = '0;
    logic        z;
    logic        a, b, c, d, busy, done, pass;
    logic [15:0] tt;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic [3:0]  vec_now;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   gray_tab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    func_min_sweep_ctrl #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .expected      (expected),
        .z             (z),
        .a             (a),
        .b             (b),
        .c             (c),
        .d             (d),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .tt            (tt),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    // Behavioural function block: z is a lookup of the current vector.
    assign vec_now = {a, b, c, d};
    assign z       = ftab[vec_now];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] vord(input int i);
`ifdef FUNC_MIN_SWEEP_GRAY_EN
        return 4'(gray_tab[i]);
`else
        return 4'(i);
`endif
    endfunction

    // Results after the first nvec vectors of the sweep have been sampled.
    function automatic exp_t model(input logic [15:0] f, input logic [15:0] e, input int nvec);
        exp_t r;
        bit   found = 0;
        r.tt = '0; r.err = '0; r.first = '0; r.done_cyc = 0;
        for (int i = 0; i < nvec; i++) begin
            logic [3:0] v = vord(i);
            r.tt[v] = f[v];
            if (f[v] != e[v]) begin
                r.err = r.err + 5'd1;
                if (!found) begin r.first = v; found = 1; end
            end
        end
        r.pass = (nvec == 16) && (r.err == 0);
        return r;
    endfunction

    // Monitor: tracks the vector sequence and busy length, pops the scoreboard on done.
    initial begin
        logic [3:0] seq[$];
        bit   prev_busy = 0;
        int   busy_cnt = 0;
        exp_t e;
        int   bad;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 0; busy_cnt = 0; seq.delete();
                continue;
            end
            if (busy && !prev_busy) begin
                seq.delete(); seq.push_back(vec_now); busy_cnt = 0;
            end else if (busy && !done && seq.size() > 0 && vec_now != seq[$]) begin
                seq.push_back(vec_now);
            end
            if (busy) busy_cnt++;
            prev_busy = busy;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    chk("busy_len", 32'(busy_cnt), 32'(SWEEP + 1));
                    chk("tt", 32'(tt), 32'(e.tt));
                    chk("err_count", 32'(err_count), 32'(e.err));
                    chk("first_err_idx", 32'(first_err_idx), 32'(e.first));
                    bad = 0;
                    if (seq.size() != 16) bad = 99;
                    else for (int i = 0; i < 16; i++) if (seq[i] != vord(i)) bad++;
                    chk("vec_order", 32'(bad), 32'd0);
                    @(negedge clk);
                    chk("done_width", 32'(done), 32'd0);
                    chk("busy_after_done", 32'(busy), 32'd0);
                    chk("pass", 32'(pass), 32'(e.pass));
                    chk("tt_hold", 32'(tt), 32'(e.tt));
                    prev_busy = busy;
                end
            end
        end
    end

    task automatic run_sweep(input logic [15:0] f, input logic [15:0] e, input int poke, input bit both);
        exp_t m;
        int   k;
        int   t;
        ftab = f; expected = e;
        @(negedge clk); start = 1'b1; abort = both;
        @(negedge clk); start = 1'b0; abort = 1'b0; k = cyc;
        m = model(f, e, 16);
        m.done_cyc = k + SWEEP;
        sb.push_back(m);
        if (poke > 0) begin
            while (cyc < k + poke - 1) @(negedge clk);
            start = 1'b1; expected = ~e;
            @(negedge clk); start = 1'b0; expected = e;
        end
        t = 0;
        while (busy && t < 400) begin @(negedge clk); t++; end
        chk("sweep_end", 32'(busy), 32'd0);
        @(negedge clk); @(negedge clk);
    endtask

    task automatic start_only(input logic [15:0] f, input logic [15:0] e, output int k);
        ftab = f; expected = e;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; k = cyc;
    endtask

    initial begin
        exp_t m;
        int   k;
        logic [15:0] f, e, msk;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_vec", 32'(vec_now), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_tt", 32'(tt), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_first", 32'(first_err_idx), 32'd0);

        run_sweep(16'hF888, 16'hF888, 0, 0);
        run_sweep(16'hF888, 16'hF889, 0, 0);
        run_sweep(16'hF888, 16'h0777, 0, 0);
        run_sweep(16'hF888, 16'hF888, 10, 0);
        run_sweep(16'hF888, 16'hF888, 0, 0);

        // abort while idle leaves results untouched
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_tt", 32'(tt), 32'hF888);
        chk("idle_abort_pass", 32'(pass), 32'd1);

        run_sweep(16'hF888, 16'hF889, 0, 1);

        // abort during vector 5
        start_only(16'hF888, 16'h0777, k);
        while (cyc < k + 16) @(negedge clk);
        chk("vec5", 32'(vec_now), 32'(vord(5)));
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        m = model(16'hF888, 16'h0777, 5);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_vec", 32'(vec_now), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_tt", 32'(tt), 32'(m.tt));
        chk("abort_err", 32'(err_count), 32'(m.err));
        repeat (SWEEP + 5) @(negedge clk);

        // reset during vector 9
        start_only(16'hF888, 16'h0777, k);
        while (cyc < k + 28) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_vec", 32'(vec_now), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_tt", 32'(tt), 32'd0);
        chk("arst_err", 32'(err_count), 32'd0);
        chk("arst_first", 32'(first_err_idx), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (SWEEP + 5) @(negedge clk);
        chk("arst_no_restart", 32'(busy), 32'd0);

        for (int n = 0; n < 10; n++) begin
            f = 16'($urandom);
            case ($urandom_range(0, 3))
                0: msk = '0;
                1: msk = 16'(1) << $urandom_range(0, 15);
                2: msk = 16'($urandom);
                default: msk = '1;
            endcase
            e = f ^ msk;
            run_sweep(f, e, (n % 3 == 0) ? int'($urandom_range(2, 40)) : 0, 1'(n % 4 == 1));
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
